// File: rtl/mips_rst_seq.sv
// Reset sequencer for the mips789 top: synchronises board reset and PLL lock, releases
// N_CH resets in order, and re-asserts them on lock loss, watchdog expiry or software request.
module mips_rst_seq #(
  parameter int               SYNC_STAGES = 2,
  parameter int               N_CH        = 3,
  parameter int               STAGE_GAP   = 16,
  parameter int               LOCK_FILTER = 8,
  parameter int               MIN_HOLD    = 32,
  parameter int               WDT_W       = 16,
  parameter logic [WDT_W-1:0] WDT_TIMEOUT = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pll_locked,
  input  logic            sw_rst_req,
  input  logic            wdt_en,
  input  logic            wdt_kick,
  output logic [N_CH-1:0] rst_o,
  output logic            sys_ready,
  output logic [1:0]      rst_cause
);

  localparam int LCW = $clog2(LOCK_FILTER + 1);
  localparam int GCW = $clog2(STAGE_GAP + 1);
  localparam int HCW = $clog2(MIN_HOLD + 1);

  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_FILTER - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(STAGE_GAP - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MIN_HOLD - 1);

  localparam logic [1:0] CAUSE_EXT = 2'd0;
  localparam logic [1:0] CAUSE_PLL = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;
  localparam logic [1:0] CAUSE_SW  = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_ASSERT
  } state_t;

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] rst_sync_reg;
  logic [SYNC_STAGES-1:0] lock_sync_reg;
  logic [LCW-1:0]         lock_cnt_reg;
  logic [GCW-1:0]         gap_cnt_reg;
  logic [HCW-1:0]         hold_cnt_reg;
  logic [WDT_W-1:0]       wdt_cnt_reg;
  logic [N_CH-1:0]        rst_o_reg;
  logic                   sys_ready_reg;
  logic [1:0]             rst_cause_reg;

  logic       irst;
  logic       lock_s;
  logic       wdt_expire;
  logic       event_hit;
  logic [1:0] event_cause;
  logic [N_CH-1:0] rst_o_shift;

  // Reset chain presets high so irst covers the whole window until deassertion is synced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_reg  <= '1;
      lock_sync_reg <= '0;
    end else begin
      rst_sync_reg  <= {rst_sync_reg[SYNC_STAGES-2:0], 1'b0};
      lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign irst   = rst_sync_reg[SYNC_STAGES-1];
  assign lock_s = lock_sync_reg[SYNC_STAGES-1];

  // A kick arriving on the expiry cycle takes precedence over the expiry.
  assign wdt_expire = (state_reg == S_RUN) && wdt_en && !wdt_kick &&
                      (wdt_cnt_reg == WDT_TIMEOUT);

  always_comb begin
    event_hit   = 1'b0;
    event_cause = CAUSE_EXT;
    if (!lock_s) begin
      event_hit   = 1'b1;
      event_cause = CAUSE_PLL;
    end else if (wdt_expire) begin
      event_hit   = 1'b1;
      event_cause = CAUSE_WDT;
    end else if (sw_rst_req) begin
      event_hit   = 1'b1;
      event_cause = CAUSE_SW;
    end
  end

  // Channels release lowest-first, so each wrap shifts one more zero in from bit 0.
  assign rst_o_shift = rst_o_reg << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_HOLD;
      rst_o_reg     <= '1;
      sys_ready_reg <= 1'b0;
      rst_cause_reg <= CAUSE_EXT;
      lock_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      hold_cnt_reg  <= '0;
      wdt_cnt_reg   <= '0;
    end else if (!irst) begin
      case (state_reg)
        S_HOLD: begin
          rst_o_reg     <= '1;
          sys_ready_reg <= 1'b0;
          if (!lock_s) begin
            lock_cnt_reg <= '0;
          end else if (lock_cnt_reg == LOCK_LAST) begin
            lock_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            state_reg    <= S_RELEASE;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + 1'b1;
          end
        end

        S_RELEASE: begin
          if (event_hit) begin
            state_reg     <= S_ASSERT;
            rst_o_reg     <= '1;
            sys_ready_reg <= 1'b0;
            rst_cause_reg <= event_cause;
            hold_cnt_reg  <= '0;
          end else if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            rst_o_reg   <= rst_o_shift;
            if (rst_o_shift == '0) begin
              state_reg <= S_RUN;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        S_RUN: begin
          if (event_hit) begin
            state_reg     <= S_ASSERT;
            rst_o_reg     <= '1;
            sys_ready_reg <= 1'b0;
            rst_cause_reg <= event_cause;
            hold_cnt_reg  <= '0;
          end else begin
            sys_ready_reg <= 1'b1;
          end
        end

        S_ASSERT: begin
          rst_o_reg     <= '1;
          sys_ready_reg <= 1'b0;
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_reg <= '0;
            lock_cnt_reg <= '0;
            state_reg    <= S_HOLD;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= S_HOLD;
      endcase

      // Watchdog saturates at the timeout value instead of wrapping.
      if ((state_reg != S_RUN) || !wdt_en || wdt_kick || event_hit) begin
        wdt_cnt_reg <= '0;
      end else if (wdt_cnt_reg != WDT_TIMEOUT) begin
        wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
      end
    end
  end

  assign rst_o     = rst_o_reg;
  assign sys_ready = sys_ready_reg;
  assign rst_cause = rst_cause_reg;

endmodule
